// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths, divisor record and helpers for the baud generator
package uart_pkg;

  // Divisor record widths; uart_baud_gen DIV_W/FRAC_W are kept equal to these
  localparam int BAUD_DIV_W  = 16;
  localparam int BAUD_FRAC_W = 4;

  // Smallest integer divisor the dividers can honour
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // Width of the oversample counter
  function automatic int os_width(input int oversample);
    return $clog2(oversample);
  endfunction

  // Raise an illegal integer divisor to the minimum
  function automatic baud_div_t clamp_div(input logic [BAUD_DIV_W-1:0]  div_int,
                                          input logic [BAUD_FRAC_W-1:0] div_frac);
    baud_div_t d;
    d.div_int  = (div_int < BAUD_DIV_W'(MIN_DIV)) ? BAUD_DIV_W'(MIN_DIV) : div_int;
    d.div_frac = div_frac;
    return d;
  endfunction

endpackage

// File: rtl/uart_frac_div.sv
// rtl/uart_frac_div.sv - fractional clock divider with oversample counter
module uart_frac_div #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OS_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              term,
  output logic              tick,
  output logic              os_wrap,
  output logic [OS_W-1:0]   os
);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [DIV_W:0]    last;
  logic [FRAC_W:0]   acc_sum;

  // Last count of this period: div_int + carry - 1 (div_int is never below 2)
  assign last    = {1'b0, div_int} + {{DIV_W{1'b0}}, carry} - {{DIV_W{1'b0}}, 1'b1};
  assign acc_sum = {1'b0, acc} + {1'b0, div_frac};

  // >= so a divisor shrunk mid-period still terminates instead of running past it
  assign term = en & ~clr & ({1'b0, cnt} >= last);

  // Count within the period, step the phase accumulator and oversample counter on wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      os      <= '0;
      tick    <= 1'b0;
      os_wrap <= 1'b0;
    end else if (!en || clr) begin
      cnt     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      os      <= '0;
      tick    <= 1'b0;
      os_wrap <= 1'b0;
    end else if (term) begin
      cnt     <= '0;
      acc     <= acc_sum[FRAC_W-1:0];
      carry   <= acc_sum[FRAC_W];
      os      <= os + 1'b1;
      tick    <= 1'b1;
      os_wrap <= &os;
    end else begin
      cnt     <= cnt + 1'b1;
      tick    <= 1'b0;
      os_wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - programmable TX/RX baud tick generator
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W        = BAUD_DIV_W,
  parameter int FRAC_W       = BAUD_FRAC_W,
  parameter int OVERSAMPLE   = 16,
  parameter int DEF_DIV_INT  = 27,
  parameter int DEF_DIV_FRAC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              rx_resync,
  output logic              tx_tick,
  output logic              rx_tick,
  output logic              rx_mid,
  output logic              cfg_err
);

  localparam int OS_W = os_width(OVERSAMPLE);
  localparam logic [OS_W-1:0] MID_OS = OS_W'(OVERSAMPLE / 2);
  localparam baud_div_t DEF_DIV = '{div_int: DIV_W'(DEF_DIV_INT), div_frac: FRAC_W'(DEF_DIV_FRAC)};

  baud_div_t act;
  baud_div_t shadow;
  baud_div_t load_val;
  logic      load_bad;
  logic      pending;
  logic      apply;
  logic      mid_armed;

  logic            rx_term;
  logic            rx_os_wrap;
  logic [OS_W-1:0] rx_os;
  logic            tx_term;
  logic            tx_os_tick;
  logic [OS_W-1:0] tx_os;
  logic            unused_div;

  assign load_val = clamp_div(div_int, div_frac);
  assign load_bad = div_int < DIV_W'(MIN_DIV);

  // A pending divisor takes effect at an RX period boundary so RX never sees a split period
  assign apply = pending & rx_term;

  // Active/shadow divisor, pending flag and sticky configuration error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act     <= DEF_DIV;
      shadow  <= DEF_DIV;
      pending <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (div_load && load_bad) begin
        cfg_err <= 1'b1;
      end
      if (div_load && !en) begin
        act     <= load_val;
        pending <= 1'b0;
      end else begin
        if (apply) begin
          act <= shadow;
        end
        if (div_load) begin
          shadow  <= load_val;
          pending <= 1'b1;
        end else if (apply) begin
          pending <= 1'b0;
        end
      end
    end
  end

  // Mid-bit strobe is armed by a resync and spent on its first use
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_armed <= 1'b0;
    end else if (!en) begin
      mid_armed <= 1'b0;
    end else if (rx_resync) begin
      mid_armed <= 1'b1;
    end else if (rx_mid) begin
      mid_armed <= 1'b0;
    end
  end

  // After a resync the RX oversample counter first reaches MID_OS on the (OVERSAMPLE/2)-th tick
  assign rx_mid = mid_armed & rx_tick & (rx_os == MID_OS);

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W),
    .OS_W   (OS_W)
  ) u_tx_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (1'b0),
    .div_int  (act.div_int),
    .div_frac (act.div_frac),
    .term     (tx_term),
    .tick     (tx_os_tick),
    .os_wrap  (tx_tick),
    .os       (tx_os)
  );

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W),
    .OS_W   (OS_W)
  ) u_rx_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (rx_resync),
    .div_int  (act.div_int),
    .div_frac (act.div_frac),
    .term     (rx_term),
    .tick     (rx_tick),
    .os_wrap  (rx_os_wrap),
    .os       (rx_os)
  );

  // Divider outputs this block has no use for
  assign unused_div = ^{tx_term, tx_os_tick, tx_os, rx_os_wrap};

endmodule
